hilo_muldiv_acc: RTL and testbench
==================================

Name: hilo_muldiv_acc

Overview:
- Next-generation HI/LO unit in the MEM stage.
- Holds a parametrised 2*XLEN HI/LO register and applies MTHI/MTLO, multiplier write-back and true 2*XLEN multiply-accumulate/subtract.
- Adds an embedded iterative signed/unsigned divider with a valid/ready handshake, busy stall and pipeline-flush abort.
- The pipeline issues one request per handshake; hilo_o feeds MFHI/MFLO forwarding.

Parameters:
- XLEN, 32, width of HI and of LO; HI/LO register is 2*XLEN.
- HILO_RST, 0, reset value of the 2*XLEN register.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present this cycle
- req_ready  out  1  unit can accept a request
- req_op  in  4  hilo_op_t: NOP, MTHI, MTLO, WRITE, MADD, MSUB, DIV, DIVU
- rs_value  in  XLEN  MTHI/MTLO source; dividend
- rt_value  in  XLEN  divisor
- hilo_i  in  2*XLEN  product from the external multiplier
- flush  in  1  pipeline flush (exception/eret); aborts pending work
- busy  out  1  divide in progress; pipeline stalls MF*/MT*/mul ops
- div_done  out  1  one-cycle pulse when a divide result is written
- hilo_o  out  2*XLEN  current register value {HI,LO}

Behaviour:
- Reset: async on rst_n low.
  - hilo <= HILO_RST; state IDLE; busy=0, div_done=0, req_ready=1.
  - Mid-divide reset discards the divide.
- Handshake: accept = req_valid & req_ready & ~flush. req_ready = (state==IDLE). NOP accepted with no effect.
- Single-cycle ops (IDLE only); write at the edge of acceptance, visible on hilo_o next cycle:
  - MTHI: {rs_value, LO}
  - MTLO: {HI, rs_value}
  - WRITE: hilo_i
  - MADD: hilo + hilo_i, full 2*XLEN add, wrap modulo 2^(2*XLEN)
  - MSUB: hilo - hilo_i, wrap
  - hilo_o is the register only; no combinational bypass.
- FSM states: IDLE, DIV_RUN, DIV_FIX.
- IDLE -> DIV_RUN on accepted DIV/DIVU with rt_value != 0.
  - Latch operands; for DIV, latch magnitudes plus quotient-sign and remainder-sign flags.
  - Counter = XLEN.
- DIV_RUN: restoring division, one quotient bit per cycle, MSB first; counter decrements. At counter==1 go to DIV_FIX.
- DIV_FIX: apply signs.
  - Quotient negated if signs differ.
  - Remainder takes the sign of the dividend.
  - At this edge: hilo <= {rem, quot}; div_done=1 in the following cycle; -> IDLE.
  - Total: result on hilo_o XLEN+1 cycles after the accept edge.
- Divide by zero: accepted, no iteration; hilo unchanged; div_done pulses the next cycle; stays IDLE.
- Overflow, DIV -2^(XLEN-1) / -1: LO = -2^(XLEN-1), HI = 0 (natural wrap); no trap.
- busy = (state != IDLE).
- flush:
  - In DIV_RUN/DIV_FIX: -> IDLE next edge; no hilo write; no div_done.
  - In IDLE: a concurrent request is dropped.
  - flush has priority over div completion in the same cycle.
- req_valid while busy: not accepted; the requester holds the request.

Decomposition:
- Package hilo_pkg:
  - hilo_op_t enum, 4 bits: NOP=0, MTHI=1, MTLO=2, WRITE=3, MADD=4, MSUB=5, DIV=6, DIVU=7.
  - div_state_t enum.
  - XLEN default constant.
- One sub-module: hilo_div_iter.
  - Contains the restoring datapath, counter and sign fix, with start/abort/done interface.
  - The top keeps the register, op decode and handshake.

Test Plan:
- Reset with rst_n=0 mid-cycle -> hilo_o=0, busy=0 immediately; MTHI 0xDEADBEEF then MTLO 0x12345678 -> hilo_o=0xDEADBEEF_12345678.
- Load hilo=0x00000000_FFFFFFFF, MADD hilo_i=1 -> 0x00000001_00000000; then MSUB hilo_i=2 -> 0x00000000_FFFFFFFE; MSUB from 0 with 1 -> 0xFFFFFFFF_FFFFFFFF.
- DIV rs=-7 (0xFFFFFFF9), rt=2 -> busy for 33 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFD; single div_done pulse. DIVU 100/7 -> HI=2, LO=14.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU 5/0 -> hilo unchanged, div_done next cycle, busy never set.
- Start DIV, assert flush at cycle 10 -> IDLE next cycle, hilo unchanged, no div_done; a request with flush=1 in IDLE is ignored.
- MTLO held with req_valid during a divide -> req_ready=0 until done; MTLO applied the cycle after return to IDLE, and HI keeps the remainder.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared types for the HI/LO multiply-accumulate and divide unit.
// Op encodings match the decode stage's hilo_op field.
package hilo_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [3:0] {
        NOP   = 4'd0,
        MTHI  = 4'd1,
        MTLO  = 4'd2,
        WRITE = 4'd3,
        MADD  = 4'd4,
        MSUB  = 4'd5,
        DIV   = 4'd6,
        DIVU  = 4'd7
    } hilo_op_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIV_RUN = 2'd1,
        DIV_FIX = 2'd2
    } div_state_t;

    function automatic logic is_div_op(hilo_op_t op);
        return (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/hilo_div_iter.sv
// Iterative restoring divider: one quotient bit per cycle, MSB first,
// magnitudes in the loop and signs applied in a final fix-up cycle.
module hilo_div_iter
    import hilo_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            is_signed,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            abort,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] quot,
    output logic [XLEN-1:0] rem
);

    localparam int CW = $clog2(XLEN + 1);

    div_state_t      state;
    logic [XLEN-1:0] dvs;
    logic [XLEN-1:0] q;
    logic [XLEN-1:0] r;
    logic            q_neg;
    logic            r_neg;
    logic [CW-1:0]   cnt;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;

    assign a_neg   = is_signed & dividend[XLEN-1];
    assign b_neg   = is_signed & divisor[XLEN-1];
    assign shifted = {r, q[XLEN-1]};
    assign diff    = shifted - {1'b0, dvs};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            dvs   <= '0;
            q     <= '0;
            r     <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        dvs   <= b_neg ? -divisor : divisor;
                        q     <= a_neg ? -dividend : dividend;
                        r     <= '0;
                        q_neg <= a_neg ^ b_neg;
                        r_neg <= a_neg;
                        cnt   <= CW'(XLEN);
                        state <= DIV_RUN;
                    end
                end
                DIV_RUN: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        // negative trial difference means restore
                        r   <= diff[XLEN] ? shifted[XLEN-1:0]
                                          : diff[XLEN-1:0];
                        q   <= {q[XLEN-2:0], ~diff[XLEN]};
                        cnt <= cnt - 1'b1;
                        if (cnt == CW'(1)) begin
                            state <= DIV_FIX;
                        end
                    end
                end
                DIV_FIX: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DIV_FIX) & ~abort;
    assign quot = q_neg ? -q : q;
    assign rem  = r_neg ? -r : r;

endmodule

// File: rtl/hilo_muldiv_acc.sv
// MEM-stage HI/LO register with move, multiply write-back,
// multiply-accumulate/subtract and an embedded iterative divider.
module hilo_muldiv_acc
    import hilo_pkg::*;
#(
    parameter int                XLEN     = XLEN_DEF,
    parameter logic [2*XLEN-1:0] HILO_RST = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [XLEN-1:0]   rs_value,
    input  logic [XLEN-1:0]   rt_value,
    input  logic [2*XLEN-1:0] hilo_i,
    input  logic              flush,
    output logic              busy,
    output logic              div_done,
    output logic [2*XLEN-1:0] hilo_o
);

    hilo_op_t          op;
    logic [2*XLEN-1:0] hilo;
    logic              accept;
    logic              is_div;
    logic              div_zero;
    logic              div_start;
    logic              div_res;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   rem;

    assign op        = hilo_op_t'(req_op);
    assign req_ready = ~busy;
    assign accept    = req_valid & req_ready & ~flush;
    assign is_div    = is_div_op(op);
    assign div_zero  = (rt_value == '0);
    assign div_start = accept & is_div & ~div_zero;

    hilo_div_iter #(
        .XLEN(XLEN)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .is_signed(op == DIV),
        .dividend (rs_value),
        .divisor  (rt_value),
        .abort    (flush),
        .busy     (busy),
        .done     (div_res),
        .quot     (quot),
        .rem      (rem)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hilo     <= HILO_RST;
            div_done <= 1'b0;
        end else begin
            // divide by zero completes at once without touching hilo
            div_done <= div_res | (accept & is_div & div_zero);
            if (div_res) begin
                hilo <= {rem, quot};
            end else if (accept) begin
                unique case (op)
                    MTHI:    hilo <= {rs_value, hilo[XLEN-1:0]};
                    MTLO:    hilo <= {hilo[2*XLEN-1:XLEN], rs_value};
                    WRITE:   hilo <= hilo_i;
                    MADD:    hilo <= hilo + hilo_i;
                    MSUB:    hilo <= hilo - hilo_i;
                    default: hilo <= hilo;
                endcase
            end
        end
    end

    assign hilo_o = hilo;

endmodule

// File: tb/tb_hilo_muldiv_acc.sv
// Scoreboard bench for hilo_muldiv_acc: directed ops push expected
// hilo values; a monitor pops on each completed op or div_done.
module tb_hilo_muldiv_acc;
    import hilo_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] rs_value;
    logic [31:0] rt_value;
    logic [63:0] hilo_i;
    logic        flush;
    logic        busy;
    logic        div_done;
    logic [63:0] hilo_o;

    int          checks;
    int          failures;
    logic [63:0] sb[$];

    hilo_muldiv_acc #(
        .XLEN    (32),
        .HILO_RST(64'h0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op   (req_op),
        .rs_value (rs_value),
        .rt_value (rt_value),
        .hilo_i   (hilo_i),
        .flush    (flush),
        .busy     (busy),
        .div_done (div_done),
        .hilo_o   (hilo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin : mon
        logic        acc;
        logic [3:0]  op;
        logic [63:0] exp;
        acc = rst_n && req_valid && req_ready && !flush;
        op  = req_op;
        #1;
        if (rst_n && ((acc && op != DIV && op != DIVU) || div_done)) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL resp_unexpected hilo_o=%h expected none",
                         hilo_o);
            end else begin
                exp = sb.pop_front();
                if (hilo_o !== exp) begin
                    failures++;
                    $display("FAIL resp_hilo got=%h exp=%h", hilo_o, exp);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [63:0] hi,
                         input logic [63:0] exp, input bit push,
                         output int waited);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        rs_value  = rs;
        rt_value  = rt;
        hilo_i    = hi;
        if (push) sb.push_back(exp);
        waited = 0;
        forever begin
            @(posedge clk);
            if (req_ready) break;
            waited++;
            if (waited > 200) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout got=%0d exp<=200", waited);
                break;
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = 4'd0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int w;
        int n;
        logic seen;
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 4'd0;
        rs_value  = '0;
        rt_value  = '0;
        hilo_i    = '0;
        flush     = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_hilo", hilo_o, 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_ready", 64'(req_ready), 64'h1);
        chk("rst_done", 64'(div_done), 64'h0);

        issue(MTHI, 32'hAAAAAAAA, 0, 0, 64'hAAAAAAAA_00000000, 1, w);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_hilo", hilo_o, 64'h0);
        chk("async_rst_busy", 64'(busy), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(MTHI, 32'hDEADBEEF, 0, 0, 64'hDEADBEEF_00000000, 1, w);
        issue(MTLO, 32'h12345678, 0, 0, 64'hDEADBEEF_12345678, 1, w);
        issue(WRITE, 0, 0, 64'h00000000_FFFFFFFF,
              64'h00000000_FFFFFFFF, 1, w);
        issue(MADD, 0, 0, 64'h1, 64'h00000001_00000000, 1, w);
        issue(MSUB, 0, 0, 64'h2, 64'h00000000_FFFFFFFE, 1, w);
        issue(WRITE, 0, 0, 64'h0, 64'h0, 1, w);
        issue(MSUB, 0, 0, 64'h1, 64'hFFFFFFFF_FFFFFFFF, 1, w);
        issue(NOP, 32'h5, 0, 64'h7, 64'hFFFFFFFF_FFFFFFFF, 1, w);

        issue(DIV, 32'hFFFFFFF9, 32'h2, 0,
              64'hFFFFFFFF_FFFFFFFD, 1, w);
        wait_idle(n);
        chk("div_busy_cycles", 64'(n), 64'd33);
        issue(DIVU, 32'd100, 32'd7, 0, 64'h00000002_0000000E, 1, w);
        wait_idle(n);
        issue(DIV, 32'd7, 32'hFFFFFFFE, 0,
              64'h00000001_FFFFFFFD, 1, w);
        wait_idle(n);
        issue(DIV, 32'h80000000, 32'hFFFFFFFF, 0,
              64'h00000000_80000000, 1, w);
        wait_idle(n);

        issue(DIVU, 32'd5, 32'd0, 0, 64'h00000000_80000000, 1, w);
        seen = 1'b0;
        repeat (3) begin
            seen = seen | busy;
            @(negedge clk);
        end
        chk("divz_busy", 64'(seen), 64'h0);

        issue(WRITE, 0, 0, 64'h11111111_22222222,
              64'h11111111_22222222, 1, w);
        issue(DIVU, 32'd100, 32'd3, 0, 64'h0, 0, w);
        repeat (9) @(negedge clk);
        chk("flush_pre_busy", 64'(busy), 64'h1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'h0);
        repeat (40) @(negedge clk);
        chk("flush_hilo", hilo_o, 64'h11111111_22222222);

        req_valid = 1'b1;
        req_op    = MTHI;
        rs_value  = 32'hFFFF0000;
        flush     = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        flush     = 1'b0;
        req_op    = 4'd0;
        @(negedge clk);
        chk("idle_flush_hilo", hilo_o, 64'h11111111_22222222);
        chk("idle_flush_busy", 64'(busy), 64'h0);

        issue(DIVU, 32'd100, 32'd7, 0, 64'h00000002_0000000E, 1, w);
        issue(MTLO, 32'hCAFEF00D, 0, 0, 64'h00000002_CAFEF00D, 1, w);
        chk("held_wait", 64'(w), 64'd32);

        repeat (5) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
